// File: rtl/dpe_pkg.sv
// rtl/dpe_pkg.sv - shared types, constants and sizing helpers for the dot product engine
package dpe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic IN_SEL_DATA   = 1'b0;
    localparam logic IN_SEL_WEIGHT = 1'b1;

    // Never returns 0 so that counters and indices always have at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int nchunk(input int acc_w, input int out_w);
        return (acc_w + out_w - 1) / out_w;
    endfunction

endpackage

// File: rtl/dpe_mac_tree.sv
// rtl/dpe_mac_tree.sv - combinational LANES-wide multiply and adder tree
module dpe_mac_tree #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic [LANES-1:0][DATA_W-1:0] data_v,
    input  logic [LANES-1:0][DATA_W-1:0] weight_v,
    input  logic                         signed_mode,
    output logic [ACC_W-1:0]             sum
);

    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;

    // Extending to the full accumulator width first makes the truncated
    // product correct modulo 2^ACC_W for both signed and unsigned operands.
    always_comb begin
        sum   = '0;
        a_ext = '0;
        b_ext = '0;
        for (int i = 0; i < LANES; i++) begin
            a_ext = {{(ACC_W-DATA_W){signed_mode & data_v[i][DATA_W-1]}}, data_v[i]};
            b_ext = {{(ACC_W-DATA_W){signed_mode & weight_v[i][DATA_W-1]}}, weight_v[i]};
            sum   = sum + a_ext * b_ext;
        end
    end

endmodule

// File: rtl/dot_product_engine.sv
// rtl/dot_product_engine.sv - operand loaders, MAC control FSM and result serialiser
module dot_product_engine
    import dpe_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sel,
    output logic              in_ready,
    input  logic              signed_mode,
    input  logic              compute,
    input  logic              acc_clear,
    input  logic              emit,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              vec_ready
);

    localparam int NCHUNK = nchunk(ACC_W, OUT_W);
    localparam int CNT_W  = clog2(LANES + 1);
    localparam int CHK_W  = clog2(NCHUNK);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LANES);
    localparam logic [CHK_W-1:0] CHK_LAST = CHK_W'(NCHUNK - 1);

    state_t state_q, state_d;
    logic [LANES-1:0][DATA_W-1:0] data_q, data_d, weight_q, weight_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d, wcnt_q, wcnt_d;
    logic signed_q, signed_d, clear_q, clear_d, emit_q, emit_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CHK_W-1:0] chunk_q, chunk_d;

    logic [ACC_W-1:0] mac_sum;
    logic accept;
    logic start;
    logic [NCHUNK*OUT_W-1:0] acc_pad;
    logic [NCHUNK-1:0][OUT_W-1:0] acc_chunks;

    dpe_mac_tree #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac_tree (
        .data_v      (data_q),
        .weight_v    (weight_q),
        .signed_mode (signed_q),
        .sum         (mac_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            data_q   <= '0;
            weight_q <= '0;
            dcnt_q   <= '0;
            wcnt_q   <= '0;
            signed_q <= 1'b0;
            clear_q  <= 1'b0;
            emit_q   <= 1'b0;
            acc_q    <= '0;
            chunk_q  <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            weight_q <= weight_d;
            dcnt_q   <= dcnt_d;
            wcnt_q   <= wcnt_d;
            signed_q <= signed_d;
            clear_q  <= clear_d;
            emit_q   <= emit_d;
            acc_q    <= acc_d;
            chunk_q  <= chunk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MAC;
            MAC:     state_d = emit_q ? SEND : IDLE;
            SEND:    if (out_ready && chunk_q == CHK_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept   = in_valid && in_ready;
        start    = (state_q == IDLE) && compute && vec_ready;
        data_d   = data_q;
        weight_d = weight_q;
        dcnt_d   = dcnt_q;
        wcnt_d   = wcnt_q;
        signed_d = signed_q;
        clear_d  = clear_q;
        emit_d   = emit_q;
        acc_d    = acc_q;
        chunk_d  = chunk_q;

        // New elements enter lane 0; beyond LANES loads the oldest falls off the top.
        if (accept && in_sel == IN_SEL_DATA) begin
            data_d = {data_q[LANES-2:0], in_data};
            if (dcnt_q != CNT_FULL) dcnt_d = dcnt_q + 1'b1;
        end else if (accept && in_sel == IN_SEL_WEIGHT) begin
            weight_d = {weight_q[LANES-2:0], in_data};
            if (wcnt_q != CNT_FULL) wcnt_d = wcnt_q + 1'b1;
        end

        if (start) begin
            signed_d = signed_mode;
            clear_d  = acc_clear;
            emit_d   = emit;
        end

        if (state_q == MAC) begin
            acc_d   = (clear_q ? '0 : acc_q) + mac_sum;
            dcnt_d  = '0;
            wcnt_d  = '0;
            chunk_d = '0;
        end

        if (state_q == SEND && out_ready) begin
            chunk_d = (chunk_q == CHK_LAST) ? '0 : chunk_q + 1'b1;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !compute;
        vec_ready = (dcnt_q == CNT_FULL) && (wcnt_q == CNT_FULL);
        busy      = (state_q != IDLE);
        out_valid = (state_q == SEND);
        out_last  = out_valid && (chunk_q == CHK_LAST);
        acc_pad   = {(NCHUNK*OUT_W){signed_q & acc_q[ACC_W-1]}};
        acc_pad[ACC_W-1:0] = acc_q;
        acc_chunks = acc_pad;
        out_data  = out_valid ? acc_chunks[chunk_q] : '0;
    end

endmodule

// File: tb/tb_dot_product_engine.sv
// tb/tb_dot_product_engine.sv - directed self-checking bench for dot_product_engine
module tb_dot_product_engine;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_sel;
    logic       in_ready;
    logic       signed_mode;
    logic       compute;
    logic       acc_clear;
    logic       emit;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       vec_ready;

    int nvec;
    int nfail;

    dot_product_engine #(
        .LANES  (4),
        .DATA_W (8),
        .ACC_W  (24),
        .OUT_W  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_sel      (in_sel),
        .in_ready    (in_ready),
        .signed_mode (signed_mode),
        .compute     (compute),
        .acc_clear   (acc_clear),
        .emit        (emit),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .vec_ready   (vec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load1(input logic sel, input logic [7:0] v);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load4(input logic sel, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        load1(sel, a);
        load1(sel, b);
        load1(sel, c);
        load1(sel, d);
    endtask

    task automatic start(input logic sm, input logic clr, input logic em);
        signed_mode = sm;
        acc_clear   = clr;
        emit        = em;
        compute     = 1'b1;
        tick();
        compute     = 1'b0;
    endtask

    // Called right after start(): the engine is in its MAC cycle.
    task automatic check_result(input string name, input logic [7:0] c0, input logic [7:0] c1,
                                input logic [7:0] c2, input logic drop);
        logic [7:0] exp_c [3];
        exp_c[0] = c0;
        exp_c[1] = c1;
        exp_c[2] = c2;
        nvec++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            nfail++;
            $display("FAIL %s_mac_cycle: busy=%b out_valid=%b, required busy=1 out_valid=0",
                     name, busy, out_valid);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            out_ready = 1'b1;
            if (drop) begin
                in_valid = 1'b1;
                in_sel   = 1'b0;
                in_data  = 8'h55;
            end
            nvec++;
            if (out_valid !== 1'b1 || out_data !== exp_c[k] || out_last !== (k == 2)) begin
                nfail++;
                $display("FAIL %s_chunk%0d: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                         name, k, out_valid, out_data, out_last, exp_c[k], (k == 2));
            end
            if (drop) begin
                nvec++;
                if (in_ready !== 1'b0) begin
                    nfail++;
                    $display("FAIL %s_in_ready_send: got %b, required 0", name, in_ready);
                end
            end
            tick();
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        nvec++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL %s_done: out_valid=%b busy=%b, required 0 0", name, out_valid, busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_sel = 1'b0; signed_mode = 1'b0;
        compute = 1'b0; acc_clear = 1'b0; emit = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        nvec++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || vec_ready !== 1'b0
            || out_data !== 8'h00 || in_ready !== 1'b1) begin
            nfail++;
            $display("FAIL reset: valid=%b last=%b busy=%b vec_ready=%b data=%h in_ready=%b, required 0 0 0 0 00 1",
                     out_valid, out_last, busy, vec_ready, out_data, in_ready);
        end
    endtask

    task automatic test_unsigned;
        load4(1'b0, 8'd1, 8'd2, 8'd3, 8'd4);
        load4(1'b1, 8'd5, 8'd6, 8'd7, 8'd8);
        nvec++;
        if (vec_ready !== 1'b1) begin
            nfail++;
            $display("FAIL unsigned_vec_ready: got %b, required 1", vec_ready);
        end
        compute = 1'b1;
        #1;
        nvec++;
        if (in_ready !== 1'b0) begin
            nfail++;
            $display("FAIL unsigned_in_ready_compute: got %b, required 0", in_ready);
        end
        compute = 1'b0;
        start(1'b0, 1'b1, 1'b1);
        check_result("unsigned", 8'h46, 8'h00, 8'h00, 1'b0);
        nvec++;
        if (vec_ready !== 1'b0) begin
            nfail++;
            $display("FAIL unsigned_counts_cleared: vec_ready=%b, required 0", vec_ready);
        end
    endtask

    task automatic test_signed;
        load4(1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        load4(1'b1, 8'h02, 8'h02, 8'h02, 8'h02);
        start(1'b1, 1'b1, 1'b1);
        check_result("signed", 8'hF8, 8'hFF, 8'hFF, 1'b0);
        load4(1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        load4(1'b1, 8'h02, 8'h02, 8'h02, 8'h02);
        start(1'b0, 1'b1, 1'b1);
        check_result("unsigned_ff", 8'hF8, 8'h07, 8'h00, 1'b0);
    endtask

    task automatic test_accumulate;
        load4(1'b0, 8'd1, 8'd2, 8'd3, 8'd4);
        load4(1'b1, 8'd5, 8'd6, 8'd7, 8'd8);
        start(1'b0, 1'b1, 1'b0);
        nvec++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            nfail++;
            $display("FAIL accum_mac: busy=%b out_valid=%b, required 1 0", busy, out_valid);
        end
        tick();
        nvec++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            nfail++;
            $display("FAIL accum_no_emit: busy=%b out_valid=%b, required 0 0", busy, out_valid);
        end
        load4(1'b0, 8'd1, 8'd2, 8'd3, 8'd4);
        load4(1'b1, 8'd5, 8'd6, 8'd7, 8'd8);
        start(1'b0, 1'b0, 1'b1);
        check_result("accum", 8'h8C, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_backpressure;
        load4(1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        load4(1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        start(1'b0, 1'b1, 1'b1);
        tick();
        out_ready = 1'b1;
        nvec++;
        if (out_valid !== 1'b1 || out_data !== 8'h04) begin
            nfail++;
            $display("FAIL bp_chunk0: valid=%b data=%h, required 1 04", out_valid, out_data);
        end
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if (out_valid !== 1'b1 || out_data !== 8'hF8 || out_last !== 1'b0) begin
                nfail++;
                $display("FAIL bp_hold%0d: valid=%b data=%h last=%b, required 1 f8 0",
                         i, out_valid, out_data, out_last);
            end
            tick();
        end
        out_ready = 1'b1;
        nvec++;
        if (out_data !== 8'hF8) begin
            nfail++;
            $display("FAIL bp_chunk1: data=%h, required f8", out_data);
        end
        tick();
        nvec++;
        if (out_valid !== 1'b1 || out_data !== 8'h03 || out_last !== 1'b1) begin
            nfail++;
            $display("FAIL bp_chunk2: valid=%b data=%h last=%b, required 1 03 1",
                     out_valid, out_data, out_last);
        end
        tick();
        out_ready = 1'b0;
        nvec++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL bp_done: valid=%b busy=%b, required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_guards;
        load1(1'b0, 8'd1);
        load1(1'b0, 8'd2);
        load1(1'b0, 8'd3);
        load4(1'b1, 8'd5, 8'd6, 8'd7, 8'd8);
        nvec++;
        if (vec_ready !== 1'b0) begin
            nfail++;
            $display("FAIL guard_partial_vec: vec_ready=%b, required 0", vec_ready);
        end
        start(1'b0, 1'b1, 1'b1);
        nvec++;
        if (busy !== 1'b0) begin
            nfail++;
            $display("FAIL guard_compute_ignored: busy=%b, required 0", busy);
        end
        load1(1'b0, 8'd4);
        load1(1'b0, 8'd9);
        nvec++;
        if (vec_ready !== 1'b1) begin
            nfail++;
            $display("FAIL guard_fifth_load: vec_ready=%b, required 1", vec_ready);
        end
        start(1'b0, 1'b1, 1'b1);
        check_result("fifth_load", 8'h80, 8'h00, 8'h00, 1'b1);
        load1(1'b0, 8'd1);
        load1(1'b0, 8'd2);
        load1(1'b0, 8'd3);
        load4(1'b1, 8'd5, 8'd6, 8'd7, 8'd8);
        nvec++;
        if (vec_ready !== 1'b0) begin
            nfail++;
            $display("FAIL guard_send_drop: vec_ready=%b, required 0", vec_ready);
        end
        load1(1'b0, 8'd4);
    endtask

    task automatic test_reset_mid_send;
        start(1'b0, 1'b1, 1'b1);
        tick();
        out_ready = 1'b1;
        nvec++;
        if (out_valid !== 1'b1 || out_data !== 8'h46) begin
            nfail++;
            $display("FAIL rst_send_chunk0: valid=%b data=%h, required 1 46", out_valid, out_data);
        end
        tick();
        out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        nvec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || vec_ready !== 1'b0 || out_data !== 8'h00) begin
            nfail++;
            $display("FAIL rst_send_cleared: valid=%b busy=%b vec_ready=%b data=%h, required 0 0 0 00",
                     out_valid, busy, vec_ready, out_data);
        end
        rst_n = 1'b1;
        tick();
        load4(1'b0, 8'd1, 8'd2, 8'd3, 8'd4);
        load4(1'b1, 8'd5, 8'd6, 8'd7, 8'd8);
        start(1'b0, 1'b0, 1'b1);
        check_result("after_reset", 8'h46, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        nvec  = 0;
        nfail = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_accumulate();
        test_backpressure();
        test_guards();
        test_reset_mid_send();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
